// File: rtl/dcache_store_port.sv
// dcache_store_port: store-side responder of the L1 data cache, direct-mapped write-back,
// write-allocate. Define DCACHE_STORE_PERF_EN to add saturating hit/miss counters.

`ifndef ADDRESS_WIDTH
`define ADDRESS_WIDTH 32
`endif
`ifndef SIZE_WRITE_WIDTH
`define SIZE_WRITE_WIDTH 2
`endif
`ifndef BYTE_SIZE
`define BYTE_SIZE 2'b00
`endif
`ifndef FULL_WORD_SIZE
`define FULL_WORD_SIZE 2'b10
`endif

module dcache_store_port #(
  parameter int unsigned WORD_SIZE        = 32,
  parameter int unsigned WIDTH            = `ADDRESS_WIDTH,
  parameter int unsigned SIZE_WRITE_WIDTH = `SIZE_WRITE_WIDTH,
  parameter int unsigned LINE_SIZE        = 128,
  parameter int unsigned N_LINES          = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cache_wenable,
  input  logic [WIDTH-1:0]            cache_physical_address,
  input  logic [WORD_SIZE-1:0]        cache_store_value,
  input  logic [SIZE_WRITE_WIDTH-1:0] cache_store_size,
  output logic                        store_success,
  output logic                        mem_req,
  output logic                        mem_req_write,
  output logic [WIDTH-1:0]            mem_req_addr,
  output logic [LINE_SIZE-1:0]        mem_req_data,
  input  logic                        mem_ready,
  input  logic [LINE_SIZE-1:0]        mem_resp_data
`ifdef DCACHE_STORE_PERF_EN
  ,
  output logic [31:0]                 hit_count,
  output logic [31:0]                 miss_count
`endif
);

  localparam int unsigned OFF_W   = $clog2(LINE_SIZE / 8);
  localparam int unsigned IDX_W   = $clog2(N_LINES);
  localparam int unsigned TAG_W   = WIDTH - IDX_W - OFF_W;
  localparam int unsigned WSEL_LO = $clog2(WORD_SIZE / 8);
  localparam int unsigned WSEL_W  = OFF_W - WSEL_LO;
  localparam logic [SIZE_WRITE_WIDTH-1:0] SizeByte = `BYTE_SIZE;

  typedef enum logic [1:0] {StIdle, StWb, StFill, StDone} state_e;

  state_e               state_q;
  logic [N_LINES-1:0]   valid_q;
  logic [N_LINES-1:0]   dirty_q;
  logic [TAG_W-1:0]     tag_q  [N_LINES];
  logic [LINE_SIZE-1:0] data_q [N_LINES];
  // Set by a fill so the retry hit that follows is not counted as a fresh hit.
  logic                 retry_q;

  logic [OFF_W-1:0]     req_off;
  logic [IDX_W-1:0]     req_idx;
  logic [TAG_W-1:0]     req_tag;
  logic [WSEL_W-1:0]    req_wsel;
  logic                 hit;
  logic                 victim_dirty;
  logic                 is_byte;
  logic [WIDTH-1:0]     fill_addr;
  logic [WIDTH-1:0]     victim_addr;
  logic [LINE_SIZE-1:0] merged_line;

  assign req_off      = cache_physical_address[OFF_W-1:0];
  assign req_idx      = cache_physical_address[OFF_W +: IDX_W];
  assign req_tag      = cache_physical_address[OFF_W + IDX_W +: TAG_W];
  assign req_wsel     = cache_physical_address[WSEL_LO +: WSEL_W];
  assign hit          = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign victim_dirty = valid_q[req_idx] && dirty_q[req_idx];
  assign is_byte      = (cache_store_size == SizeByte);
  assign fill_addr    = {req_tag, req_idx, {OFF_W{1'b0}}};
  assign victim_addr  = {tag_q[req_idx], req_idx, {OFF_W{1'b0}}};

  // Unknown size codes fall through to a full-word write.
  always_comb begin
    merged_line = data_q[req_idx];
    if (is_byte) begin
      merged_line[req_off * 8 +: 8] = cache_store_value[7:0];
    end else begin
      merged_line[req_wsel * WORD_SIZE +: WORD_SIZE] = cache_store_value;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      store_success <= 1'b0;
      mem_req       <= 1'b0;
      mem_req_write <= 1'b0;
      mem_req_addr  <= '0;
      mem_req_data  <= '0;
      valid_q       <= '0;
      dirty_q       <= '0;
      retry_q       <= 1'b0;
      for (int i = 0; i < int'(N_LINES); i++) begin
        tag_q[i]  <= '0;
        data_q[i] <= '0;
      end
`ifdef DCACHE_STORE_PERF_EN
      hit_count  <= '0;
      miss_count <= '0;
`endif
    end else begin
      case (state_q)
        StIdle: begin
          if (cache_wenable) begin
            if (hit) begin
              data_q[req_idx]  <= merged_line;
              dirty_q[req_idx] <= 1'b1;
              store_success    <= 1'b1;
              retry_q          <= 1'b0;
              state_q          <= StDone;
`ifdef DCACHE_STORE_PERF_EN
              if (!retry_q && hit_count != '1) hit_count <= hit_count + 32'd1;
`endif
            end else begin
              mem_req <= 1'b1;
`ifdef DCACHE_STORE_PERF_EN
              if (miss_count != '1) miss_count <= miss_count + 32'd1;
`endif
              if (victim_dirty) begin
                mem_req_write <= 1'b1;
                mem_req_addr  <= victim_addr;
                mem_req_data  <= data_q[req_idx];
                state_q       <= StWb;
              end else begin
                mem_req_write <= 1'b0;
                mem_req_addr  <= fill_addr;
                state_q       <= StFill;
              end
            end
          end
        end
        StWb: begin
          if (mem_ready) begin
            dirty_q[req_idx] <= 1'b0;
            mem_req          <= 1'b0;
            state_q          <= StFill;
          end
        end
        StFill: begin
          // After a write-back the request drops for one cycle before the fill goes out.
          if (!mem_req) begin
            mem_req       <= 1'b1;
            mem_req_write <= 1'b0;
            mem_req_addr  <= fill_addr;
          end else if (mem_ready) begin
            data_q[req_idx]  <= mem_resp_data;
            tag_q[req_idx]   <= req_tag;
            valid_q[req_idx] <= 1'b1;
            dirty_q[req_idx] <= 1'b0;
            mem_req          <= 1'b0;
            retry_q          <= 1'b1;
            state_q          <= StIdle;
          end
        end
        StDone: begin
          store_success <= 1'b0;
          state_q       <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_store_port.sv
// Scoreboard bench for dcache_store_port: a byte-level cache/memory model predicts every
// memory transaction and completion pulse; a monitor pops and compares as the DUT emits them.
module tb_dcache_store_port;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_WORD = 2'b10;

  logic         clk;
  logic         rst;
  logic         cache_wenable;
  logic [31:0]  cache_physical_address;
  logic [31:0]  cache_store_value;
  logic [1:0]   cache_store_size;
  logic         store_success;
  logic         mem_req;
  logic         mem_req_write;
  logic [31:0]  mem_req_addr;
  logic [127:0] mem_req_data;
  logic         mem_ready;
  logic [127:0] mem_resp_data;
`ifdef DCACHE_STORE_PERF_EN
  logic [31:0]  hit_count;
  logic [31:0]  miss_count;
`endif

  dcache_store_port dut (
    .clk                    (clk),
    .rst                    (rst),
    .cache_wenable          (cache_wenable),
    .cache_physical_address (cache_physical_address),
    .cache_store_value      (cache_store_value),
    .cache_store_size       (cache_store_size),
    .store_success          (store_success),
    .mem_req                (mem_req),
    .mem_req_write          (mem_req_write),
    .mem_req_addr           (mem_req_addr),
    .mem_req_data           (mem_req_data),
    .mem_ready              (mem_ready),
    .mem_resp_data          (mem_resp_data)
`ifdef DCACHE_STORE_PERF_EN
    ,
    .hit_count              (hit_count),
    .miss_count             (miss_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp  = 0;
  int n_fail = 0;

  // kind: 0 = write-back, 1 = fill, 2 = completion pulse; at_cyc = -1 means any cycle.
  typedef struct {
    int           kind;
    logic [31:0]  addr;
    logic [127:0] data;
    int           at_cyc;
  } exp_t;
  exp_t expq[$];

  // Reference model: 4 lines of 16 bytes, plus the backing memory keyed by line address.
  bit           m_valid [4];
  bit           m_dirty [4];
  int unsigned  m_tag   [4];
  logic [7:0]   m_bytes [4][16];
  logic [127:0] backing [logic [31:0]];
  int           m_hits   = 0;
  int           m_misses = 0;
  bit           hold_fill = 1'b0;

  function automatic logic [127:0] line_of(input int idx);
    logic [127:0] l;
    for (int b = 0; b < 16; b++) l[b*8 +: 8] = m_bytes[idx][b];
    return l;
  endfunction

  task automatic model_store(input logic [31:0] a, input logic [31:0] v, input logic [1:0] s,
                             input int hit_cyc);
    int           idx = int'((a >> 4) & 32'd3);
    int unsigned  tag = a >> 6;
    int           off = int'(a & 32'hF);
    logic [31:0]  laddr = a & 32'hFFFF_FFF0;
    logic [127:0] fl;
    exp_t         e;
    int           when = hit_cyc;
    if (m_valid[idx] && m_tag[idx] == tag) begin
      m_hits++;
    end else begin
      m_misses++;
      when = -1;
      if (m_valid[idx] && m_dirty[idx]) begin
        e.kind = 0; e.addr = (m_tag[idx] << 6) | (idx << 4); e.data = line_of(idx); e.at_cyc = -1;
        expq.push_back(e);
        backing[e.addr] = e.data;
      end
      if (!backing.exists(laddr)) backing[laddr] = {$urandom, $urandom, $urandom, $urandom};
      fl = backing[laddr];
      e.kind = 1; e.addr = laddr; e.data = '0; e.at_cyc = -1;
      expq.push_back(e);
      for (int b = 0; b < 16; b++) m_bytes[idx][b] = fl[b*8 +: 8];
      m_valid[idx] = 1'b1;
      m_tag[idx]   = tag;
    end
    if (s == SZ_BYTE) m_bytes[idx][off] = v[7:0];
    else for (int k = 0; k < 4; k++) m_bytes[idx][(off & ~3) + k] = v[k*8 +: 8];
    m_dirty[idx] = 1'b1;
    e.kind = 2; e.addr = '0; e.data = '0; e.at_cyc = when;
    expq.push_back(e);
  endtask

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, want);
    end
  endtask

  // Memory responder: random latency, one-cycle mem_ready per request.
  int rcnt = -1;
  initial begin
    mem_ready     = 1'b0;
    mem_resp_data = '0;
    forever begin
      @(negedge clk);
      if (mem_ready) begin
        mem_ready = 1'b0;
        rcnt      = -1;
      end else if (rst || !mem_req || (hold_fill && !mem_req_write)) begin
        rcnt = -1;
      end else begin
        if (rcnt < 0) rcnt = $urandom_range(0, 3);
        if (rcnt == 0) begin
          mem_ready     = 1'b1;
          mem_resp_data = (!mem_req_write && backing.exists(mem_req_addr)) ?
                          backing[mem_req_addr] : '0;
        end else begin
          rcnt--;
        end
      end
    end
  end

  // Monitor: one pop per new memory request and per completion-pulse cycle.
  bit   prev_req = 1'b0;
  exp_t me;
  initial begin
    forever begin
      @(negedge clk);
      if (mem_req && !prev_req) begin
        n_cmp++;
        if (expq.size() == 0) begin
          n_fail++;
          $display("FAIL sb_req: got write=%0b addr=%h, expected no request",
                   mem_req_write, mem_req_addr);
        end else begin
          me = expq.pop_front();
          if (me.kind == 2 || (me.kind == 0) != mem_req_write || mem_req_addr !== me.addr ||
              (me.kind == 0 && mem_req_data !== me.data)) begin
            n_fail++;
            $display("FAIL sb_req: got write=%0b addr=%h data=%h, expected kind=%0d addr=%h data=%h",
                     mem_req_write, mem_req_addr, mem_req_data, me.kind, me.addr, me.data);
          end
        end
      end
      prev_req = mem_req;
      if (store_success) begin
        n_cmp++;
        if (expq.size() == 0) begin
          n_fail++;
          $display("FAIL sb_success: got pulse at cycle %0d, expected none", cyc);
        end else begin
          me = expq.pop_front();
          if (me.kind != 2 || (me.at_cyc >= 0 && me.at_cyc != cyc)) begin
            n_fail++;
            $display("FAIL sb_success: got pulse at cycle %0d, expected kind=%0d cycle=%0d",
                     cyc, me.kind, me.at_cyc);
          end
        end
      end
    end
  end

  // Called on a negedge; returns on the negedge where the completion pulse is visible.
  task automatic issue(input logic [31:0] a, input logic [31:0] v, input logic [1:0] s);
    int lat = store_success ? 2 : 1;
    int n   = 0;
    model_store(a, v, s, cyc + lat);
    cache_wenable          = 1'b1;
    cache_physical_address = a;
    cache_store_value      = v;
    cache_store_size       = s;
    do begin
      @(negedge clk);
      n++;
    end while (!store_success && n < 400);
    if (!store_success) begin
      n_cmp++;
      n_fail++;
      $display("FAIL timeout: store to %h got no pulse, expected one within 400 cycles", a);
    end
    cache_wenable = 1'b0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
    expq.delete();
    m_hits   = 0;
    m_misses = 0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation got stuck, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst                    = 1'b1;
    cache_wenable          = 1'b0;
    cache_physical_address = '0;
    cache_store_value      = '0;
    cache_store_size       = SZ_WORD;
    backing[32'h0]         = '0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_store_success", {127'b0, store_success}, 0);
    chk("rst_mem_req", {127'b0, mem_req}, 0);
    chk("rst_mem_req_write", {127'b0, mem_req_write}, 0);
    chk("rst_mem_req_addr", {96'b0, mem_req_addr}, 0);
    chk("rst_mem_req_data", mem_req_data, 0);
    rst = 1'b0;
    @(negedge clk);

    issue(32'h4, 32'd26, SZ_WORD);
    @(negedge clk);
    issue(32'hD, 32'hAB, SZ_BYTE);
    @(negedge clk);
    issue(32'h44, 32'd7, SZ_WORD);
`ifdef DCACHE_STORE_PERF_EN
    chk("hit_count_s3", {96'b0, hit_count}, m_hits);
    chk("miss_count_s3", {96'b0, miss_count}, m_misses);
`endif
    @(negedge clk);
    issue(32'h40, 32'h1111_0001, SZ_WORD);
    issue(32'h48, 32'h2222_0002, SZ_WORD);
    issue(32'h4C, 32'h33, SZ_BYTE);

    // Reset while the fill for 0x84 is outstanding.
    @(negedge clk);
    hold_fill = 1'b1;
    model_store(32'h84, 32'h5A5A_0084, SZ_WORD, -1);
    cache_wenable          = 1'b1;
    cache_physical_address = 32'h84;
    cache_store_value      = 32'h5A5A_0084;
    cache_store_size       = SZ_WORD;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(mem_req && !mem_req_write) && n < 200);
    if (n >= 200) begin
      n_cmp++;
      n_fail++;
      $display("FAIL fill_wait: got no fill request, expected one within 200 cycles");
    end
    @(negedge clk);
    rst           = 1'b1;
    cache_wenable = 1'b0;
    @(negedge clk);
    chk("abort_mem_req", {127'b0, mem_req}, 0);
    chk("abort_store_success", {127'b0, store_success}, 0);
    rst       = 1'b0;
    hold_fill = 1'b0;
    model_reset();
    @(negedge clk);
    issue(32'h4, 32'hCAFE_0004, SZ_WORD);

    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 2) == 0) @(negedge clk);
      issue(32'($urandom_range(0, 255)), $urandom, 2'($urandom_range(0, 3)));
    end

    repeat (6) @(negedge clk);
    chk("queue_drained", 128'(expq.size()), 0);
`ifdef DCACHE_STORE_PERF_EN
    chk("hit_count_end", {96'b0, hit_count}, m_hits);
    chk("miss_count_end", {96'b0, miss_count}, m_misses);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/dcache_store_port.md
# dcache_store_port

Store-side responder of the L1 data cache. It accepts committed stores drained from the store buffer on the `cache_*` write interface, merges them into a small direct-mapped write-back line array, and returns a one-cycle `store_success` pulse when the store is globally performed. Misses are handled with a write-allocate policy: a dirty victim is written back, the line is filled over a single-request memory interface, and the store is then retried.

## Interface
Parameters:
- WORD_SIZE, 32, store data width in bits.
- WIDTH, 32, physical address width (`ADDRESS_WIDTH`).
- SIZE_WRITE_WIDTH, `SIZE_WRITE_WIDTH`, width of the store-size code.
- LINE_SIZE, 128, line width in bits (4 words, 16 bytes).
- N_LINES, 4, number of direct-mapped lines (power of two).

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous active-high reset.
- cache_wenable  in  1  store request valid; held with stable fields until `store_success`.
- cache_physical_address  in  WIDTH  store byte address.
- cache_store_value  in  WORD_SIZE  store data, LSB-aligned.
- cache_store_size  in  SIZE_WRITE_WIDTH  `BYTE_SIZE` or `FULL_WORD_SIZE`.
- store_success  out  1  one-cycle completion pulse, registered.
- mem_req  out  1  memory request valid, registered.
- mem_req_write  out  1  1 = line write-back, 0 = line fill.
- mem_req_addr  out  WIDTH  line-aligned address (low 4 bits zero).
- mem_req_data  out  LINE_SIZE  victim line for write-back.
- mem_ready  in  1  one-cycle memory completion; fill data valid this cycle.
- mem_resp_data  in  LINE_SIZE  fill line.

## Operation
- Address split: offset [3:0], index [3+log2(N_LINES):4], tag the remaining high bits. Per line: valid, dirty, tag, data.
- Word store: writes the word selected by addr[3:2]; addr[1:0] are ignored.
- Byte store: writes `cache_store_value[7:0]` into the byte selected by addr[3:0]; other bytes unchanged.
- Any other size code is treated as `FULL_WORD_SIZE`.
- FSM states:
  - IDLE: if `cache_wenable` and hit, write and set dirty, then go to DONE.
    - On a miss with the victim valid and dirty, go to WB.
    - On a miss otherwise, go to FILL.
  - WB: `mem_req`=1, `mem_req_write`=1, addr = {victim tag, index, 4'b0}, data = victim line. On `mem_ready`, clear the victim's dirty bit and go to FILL.
  - FILL: `mem_req`=1, `mem_req_write`=0, addr = request line address. On `mem_ready`, install `mem_resp_data`, set valid=1, dirty=0, tag, then go to IDLE. The store is re-looked-up there and hits.
  - DONE: `store_success`=1 for this cycle only. No request is sampled. Return to IDLE.
- `mem_req` and its fields stay stable until the `mem_ready` cycle. `mem_req` is low the following cycle.
- `mem_ready` outside WB/FILL is ignored.

## Timing
- Reset values: `store_success`=0, `mem_req`=0, `mem_req_write`=0, `mem_req_addr`=0, `mem_req_data`=0. All valid/dirty bits are cleared, data and tags are zeroed, and the state is IDLE.
- Hit: request seen at edge E, `store_success` high in cycle E+1. The earliest next acceptance is edge E+2, so the hit throughput is one store per 2 cycles.
- Clean miss: `mem_req` is high from cycle E+1 until `mem_ready`. Install on that edge, IDLE hit on the next edge, then the pulse.
- Dirty miss: the WB transaction, then the FILL transaction as above.
- `rst` mid-operation wins over everything. The FSM returns to IDLE, the outstanding memory transaction is abandoned, and no `store_success` is issued for the aborted store.
- `cache_wenable` dropping without a success is a protocol violation; behaviour is undefined.

## Configuration
- `DCACHE_STORE_PERF_EN` defined:
  - Adds outputs `hit_count` and `miss_count`, 32 bits each.
  - Both reset to 0 and saturate at 0xFFFFFFFF.
  - `hit_count` increments on each IDLE hit.
  - `miss_count` increments on each IDLE miss. The retry hit after a fill is not counted as a hit.
- Not defined: the ports and counters are absent, and functional behaviour is identical.

## Test plan
- Reset, then a word store of 26 to 0x4:
  - `mem_req`=1, `mem_req_write`=0, `mem_req_addr`=0x0.
  - Assert `mem_ready` with data 0 three cycles later.
  - Then exactly one `store_success` pulse; line 0 word1 = 26, dirty = 1.
- Byte store of 0xAB to 0xD: hit, `store_success` high exactly one cycle after the request, line 0 word3 = 0x0000AB00.
- Word store of 7 to 0x44 (index 0, new tag):
  - First a write-back with `mem_req_addr`=0x0 and `mem_req_data`[63:32]=26, [127:96]=0x0000AB00.
  - After `mem_ready`, a fill with `mem_req_addr`=0x40, then the success pulse.
- Three back-to-back hit stores to 0x40, 0x48 and 0x4C: `store_success` pulses 2 cycles apart, and there is no `mem_req`.
- Assert `rst` while in FILL: the next cycle `mem_req`=0 and `store_success`=0. A store to 0x4 afterwards misses again.
- With `DCACHE_STORE_PERF_EN` defined, after the sequence of the first three scenarios: `hit_count`=1, `miss_count`=2.
